// File: rtl/csr_pkg.sv
// csr_pkg: CSR addresses, writable masks, op encoding and mstatus fields
// shared by the machine-mode CSR file.
package csr_pkg;

  localparam int unsigned CSR_AW = 12;

  // CSR addresses
  localparam logic [CSR_AW-1:0] CSR_MSTATUS       = 12'h300;
  localparam logic [CSR_AW-1:0] CSR_MISA          = 12'h301;
  localparam logic [CSR_AW-1:0] CSR_MIE           = 12'h304;
  localparam logic [CSR_AW-1:0] CSR_MTVEC         = 12'h305;
  localparam logic [CSR_AW-1:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [CSR_AW-1:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [CSR_AW-1:0] CSR_MEPC          = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE        = 12'h342;
  localparam logic [CSR_AW-1:0] CSR_MTVAL         = 12'h343;
  localparam logic [CSR_AW-1:0] CSR_MIP           = 12'h344;
  localparam logic [CSR_AW-1:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [CSR_AW-1:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [CSR_AW-1:0] CSR_MHPMCOUNTER3  = 12'hB03;
  localparam logic [CSR_AW-1:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [CSR_AW-1:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [CSR_AW-1:0] CSR_MHPMCOUNTER3H = 12'hB83;
  localparam logic [CSR_AW-1:0] CSR_MHARTID       = 12'hF14;

  // Writable-bit masks; bits outside a mask keep their stored value
  localparam logic [31:0] MSTATUS_WMASK   = 32'h0000_1888;
  localparam logic [31:0] MIE_WMASK       = 32'h0000_0888;
  localparam logic [31:0] MIP_WMASK       = 32'h0000_0008;
  localparam logic [31:0] MTVEC_WMASK     = 32'hFFFF_FFFC;
  localparam logic [31:0] MSCRATCH_WMASK  = 32'hFFFF_FFFF;
  localparam logic [31:0] MEPC_WMASK      = 32'hFFFF_FFFC;
  localparam logic [31:0] MCAUSE_WMASK    = 32'hFFFF_FFFF;
  localparam logic [31:0] MTVAL_WMASK     = 32'hFFFF_FFFF;
  localparam logic [31:0] MINH_BASE_WMASK = 32'h0000_0005;

  // Constants and reset values
  localparam logic [31:0] MISA_VAL    = 32'h4000_0100;
  localparam logic [31:0] MSTATUS_RST = 32'h0000_1800;

  // mstatus field positions
  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;
  localparam int unsigned MSTATUS_MPP  = 11;

  typedef enum logic [1:0] {
    OP_ILL = 2'b00,
    OP_RW  = 2'b01,
    OP_RS  = 2'b10,
    OP_RC  = 2'b11
  } csr_op_e;

  // mcountinhibit mask: CY, IR, plus one bit per implemented hpm counter
  function automatic logic [31:0] minh_mask(input int unsigned n_hpm, input bit hpm_en);
    logic [31:0] m;
    m = MINH_BASE_WMASK;
    if (hpm_en) begin
      for (int unsigned i = 0; i < n_hpm && i < 29; i++) m[i+3] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit event counter with inhibit and 32-bit half-write port.
// A half write takes priority and drops that cycle's increment.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inhibit,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  // Count register: reset, half write, or gated increment with silent wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= '0;
    end else if (wr_lo) begin
      value[31:0] <= wdata;
    end else if (wr_hi) begin
      value[63:32] <= wdata;
    end else if (inc && !inhibit) begin
      value <= value + 64'd1;
    end
  end

endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file with a one-cycle request/response port,
// trap/mret state updates and 64-bit counters.
// Build option: define CSR_HPM_EN to implement the mhpmcounter set.
module csr_file
  import csr_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_HPM = 4,
  parameter int unsigned HARTID  = 0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  req_v,
  output logic                                  req_rdy,
  input  logic [1:0]                            op,
  input  logic                                  use_imm,
  input  logic [4:0]                            imm,
  input  logic [XLEN-1:0]                       rs1,
  input  logic [11:0]                           addr,
  input  logic [4:0]                            rd_i,
  input  logic                                  instret_v,
  input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_evt,
  input  logic                                  trap_v,
  input  logic [XLEN-1:0]                       trap_cause,
  input  logic [XLEN-1:0]                       trap_pc,
  input  logic [XLEN-1:0]                       trap_val,
  input  logic                                  mret_v,
  output logic [XLEN-1:0]                       mtvec_o,
  output logic [XLEN-1:0]                       mepc_o,
  output logic                                  rsp_v,
  input  logic                                  rsp_rdy,
  output logic [XLEN-1:0]                       rsp_data,
  output logic [4:0]                            rsp_rd,
  output logic                                  rsp_fault
);

  localparam int unsigned NUM_CNT = 2 + NUM_HPM;
`ifdef CSR_HPM_EN
  localparam bit HPM_EN = 1'b1;
`else
  localparam bit HPM_EN = 1'b0;
`endif
  localparam logic [XLEN-1:0] MINH_MASK = minh_mask(NUM_HPM, HPM_EN);

  logic [XLEN-1:0] mstatus, mie, mip, mtvec, mscratch, mepc, mcause, mtval, minh;
  logic [63:0]     cnt_val [NUM_CNT];
  logic [63:0]     cnt_rd;
  csr_op_e         op_e;
  logic            accept, fault, eff_wr, wr_en, rd_ok, is_cnt, cnt_hi;
  logic [4:0]      cnt_idx;
  logic [XLEN-1:0] src, rd_val, wmask, wr_raw, wr_val;

  assign op_e    = csr_op_e'(op);
  assign src     = use_imm ? XLEN'(imm) : rs1;
  assign req_rdy = rst_n && (!rsp_v || rsp_rdy) && !trap_v && !mret_v;
  assign accept  = req_v && req_rdy;
  assign eff_wr  = (op_e == OP_RW) || (src != '0);
  assign fault   = !rd_ok || (op_e == OP_ILL) || (eff_wr && addr[11:10] == 2'b11);
  assign wr_en   = accept && !fault && eff_wr;
  assign mtvec_o = mtvec;
  assign mepc_o  = mepc;

  // Select the addressed counter without indexing past the array
  always_comb begin
    cnt_rd = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      if (cnt_idx == 5'(k)) cnt_rd = cnt_val[k];
    end
  end

  // Address decode: read value, writable mask and counter selection
  always_comb begin
    rd_val  = '0;
    wmask   = '0;
    rd_ok   = 1'b1;
    is_cnt  = 1'b0;
    cnt_hi  = addr[7];
    cnt_idx = '0;
    case (addr)
      CSR_MHARTID:       rd_val = XLEN'(HARTID);
      CSR_MISA:          rd_val = MISA_VAL;
      CSR_MSTATUS:       begin rd_val = mstatus;  wmask = MSTATUS_WMASK;  end
      CSR_MIE:           begin rd_val = mie;      wmask = MIE_WMASK;      end
      CSR_MIP:           begin rd_val = mip;      wmask = MIP_WMASK;      end
      CSR_MTVEC:         begin rd_val = mtvec;    wmask = MTVEC_WMASK;    end
      CSR_MSCRATCH:      begin rd_val = mscratch; wmask = MSCRATCH_WMASK; end
      CSR_MEPC:          begin rd_val = mepc;     wmask = MEPC_WMASK;     end
      CSR_MCAUSE:        begin rd_val = mcause;   wmask = MCAUSE_WMASK;   end
      CSR_MTVAL:         begin rd_val = mtval;    wmask = MTVAL_WMASK;    end
      CSR_MCOUNTINHIBIT: begin rd_val = minh;     wmask = MINH_MASK;      end
      default: begin
        // Counter windows 0xB00-0xB1F (low halves) and 0xB80-0xB9F (high halves)
        if (addr[11:8] == 4'hB && addr[6:5] == 2'b00) begin
          if (addr[4:0] == 5'd0) begin
            is_cnt  = 1'b1;
            cnt_idx = 5'd0;
          end else if (addr[4:0] == 5'd2) begin
            is_cnt  = 1'b1;
            cnt_idx = 5'd1;
          end else if (HPM_EN && addr[4:0] >= 5'd3 && 32'(addr[4:0]) < NUM_HPM + 32'd3) begin
            is_cnt  = 1'b1;
            cnt_idx = addr[4:0] - 5'd1;
          end
        end
        rd_ok = is_cnt;
        if (is_cnt) begin
          wmask  = '1;
          rd_val = cnt_hi ? cnt_rd[63:32] : cnt_rd[31:0];
        end
      end
    endcase
  end

  // Write value: RW/RS/RC result merged through the writable mask
  always_comb begin
    wr_raw = src;
    case (op_e)
      OP_RS:   wr_raw = rd_val | src;
      OP_RC:   wr_raw = rd_val & ~src;
      default: wr_raw = src;
    endcase
    wr_val = (rd_val & ~wmask) | (wr_raw & wmask);
  end

  // Architectural CSR state; trap and mret never coincide with an accepted request
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstatus  <= MSTATUS_RST;
      mie      <= '0;
      mip      <= '0;
      mtvec    <= '0;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mtval    <= '0;
      minh     <= '0;
    end else if (trap_v) begin
      mepc                       <= trap_pc & ~XLEN'(3);
      mcause                     <= trap_cause;
      mtval                      <= trap_val;
      mstatus[MSTATUS_MPIE]      <= mstatus[MSTATUS_MIE];
      mstatus[MSTATUS_MIE]       <= 1'b0;
      mstatus[MSTATUS_MPP +: 2]  <= 2'b11;
    end else if (mret_v) begin
      mstatus[MSTATUS_MIE]       <= mstatus[MSTATUS_MPIE];
      mstatus[MSTATUS_MPIE]      <= 1'b1;
    end else if (wr_en) begin
      case (addr)
        CSR_MSTATUS:       mstatus  <= wr_val;
        CSR_MIE:           mie      <= wr_val;
        CSR_MIP:           mip      <= wr_val;
        CSR_MTVEC:         mtvec    <= wr_val;
        CSR_MSCRATCH:      mscratch <= wr_val;
        CSR_MEPC:          mepc     <= wr_val;
        CSR_MCAUSE:        mcause   <= wr_val;
        CSR_MTVAL:         mtval    <= wr_val;
        CSR_MCOUNTINHIBIT: minh     <= wr_val;
        default: ;
      endcase
    end
  end

  // Response register: loads on accept, holds until consumed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_v     <= 1'b0;
      rsp_data  <= '0;
      rsp_rd    <= '0;
      rsp_fault <= 1'b0;
    end else if (accept) begin
      rsp_v     <= 1'b1;
      rsp_data  <= fault ? '0 : rd_val;
      rsp_rd    <= rd_i;
      rsp_fault <= fault;
    end else if (rsp_rdy) begin
      rsp_v     <= 1'b0;
    end
  end

  // Counters: 0 = mcycle, 1 = minstret, 2.. = mhpmcounter3..
  for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
    logic inh, inc;
    if (k == 0) begin : g_cy
      assign inh = minh[0];
      assign inc = 1'b1;
    end else if (k == 1) begin : g_ir
      assign inh = minh[2];
      assign inc = instret_v;
    end else begin : g_hpm
      assign inh = minh[k+1];
      assign inc = HPM_EN & hpm_evt[k-2];
    end
    csr_counter64 u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inhibit (inh),
      .inc     (inc),
      .wr_lo   (wr_en && is_cnt && !cnt_hi && cnt_idx == 5'(k)),
      .wr_hi   (wr_en && is_cnt &&  cnt_hi && cnt_idx == 5'(k)),
      .wdata   (wr_val),
      .value   (cnt_val[k])
    );
  end

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 Parameter XLEN, default 32: CSR and datapath width; only 32 is supported.
REQ-002 Parameter NUM_HPM, default 4, legal 0..29: number of mhpmcounter3.. counters implemented.
REQ-003 Parameter HARTID, default 0: constant value returned by mhartid.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset; synchronous, active-low.
REQ-006 req_v / req_rdy  in / out  1 / 1  CSR request valid; request accepted.
REQ-007 op  in  2  operation: 01 = RW, 10 = RS, 11 = RC; 00 is illegal and raises a fault.
REQ-008 use_imm, imm, rs1  in  1, 5, XLEN  source select; zero-extended imm, or rs1.
REQ-009 addr, rd_i  in  12, 5  CSR address; destination register tag.
REQ-010 instret_v, hpm_evt  in  1, NUM_HPM  retire pulse; per-counter event pulses.
REQ-011 trap_v, trap_cause, trap_pc, trap_val  in  1, XLEN x3  trap entry request.
REQ-012 mret_v  in  1  mret commit.
REQ-013 mtvec_o, mepc_o  out  XLEN  live register values for fetch redirect.
REQ-014 rsp_v / rsp_rdy  out / in  1 / 1  response valid; response consumed.
REQ-015 rsp_data, rsp_rd, rsp_fault  out  XLEN, 5, 1  old CSR value, tag, access fault.

Function
REQ-016 Handshake: a request is accepted when req_v && req_rdy.
- req_rdy = (!rsp_v || rsp_rdy) && !trap_v && !mret_v.
REQ-017 Response timing: the response appears exactly 1 cycle after acceptance.
- The response holds stable while rsp_v && !rsp_rdy.
- Back-to-back requests sustain one per cycle.
REQ-018 rsp_data is the pre-write CSR value.
- For a 64-bit counter, the selected half is returned, sampled before any same-cycle increment.
REQ-019 Write value, src = use_imm ? imm : rs1:
- RW: src.
- RS: old | src.
- RC: old & ~src.
- The result is then merged through the per-CSR writable mask from the package.
REQ-020 A write is suppressed when op is RS or RC and src == 0; the read still occurs.
REQ-021 Fault conditions; on a fault rsp_fault=1, rsp_data=0 and no state changes:
- unimplemented address;
- op==00;
- effective write to a read-only address (addr[11:10]==2'b11).
REQ-022 Implemented CSRs:
- mhartid, misa (read-only constant 0x40000100), mstatus, mie, mip, mtvec, mscratch, mepc, mcause, mtval, mcountinhibit;
- mcycle[h], minstret[h], mhpmcounter3..(2+NUM_HPM)[h].
REQ-023 Counter increments: mcycle +1 each cycle; minstret +1 on instret_v; hpm i +1 on hpm_evt[i].
- Each increment is gated by its mcountinhibit bit.
- 64-bit wrap from all-ones to 0 is silent.
REQ-024 A CSR write to a counter half in the same cycle as its increment takes priority; the increment is dropped that cycle.
REQ-025 On trap_v:
- mepc <= trap_pc & ~3; mcause <= trap_cause; mtval <= trap_val;
- mstatus.MPIE <= MIE; MIE <= 0; MPP <= 2'b11.
REQ-026 On mret_v: mstatus.MIE <= MPIE; MPIE <= 1.
REQ-027 trap_v together with mret_v: trap wins and mret is ignored.
REQ-028 mtvec_o and mepc_o reflect the register state and update the cycle after a write or trap.

Reset
REQ-029 While rst_n=0:
- rsp_v=0; rsp_data=0; rsp_rd=0; rsp_fault=0;
- mstatus=0x00001800; all other writable CSRs and counters = 0;
- no request is accepted and counters do not increment.
REQ-030 Reset asserted mid-operation discards any pending response; the first valid cycle after release samples fresh inputs.

Configuration
REQ-031 Macro CSR_HPM_EN.
- Defined: the mhpmcounter set, hpm_evt and the upper mcountinhibit bits are implemented.
- Undefined: hpm_evt is ignored, hpm addresses fault, and mcountinhibit bits 3+ read 0.

Structure
REQ-032 Package csr_pkg holds:
- the CSR address constants;
- the per-CSR writable masks;
- the op enum;
- the mstatus field bit positions;
- the misa reset constant.
REQ-033 Sub-module csr_counter64 (64-bit counter with inhibit, increment, and half-write port) is instantiated 2+NUM_HPM times.

Verification
REQ-034 RW mscratch 0xDEADBEEF, then RS mscratch imm=0x5 -> rsp_data 0x0, then 0xDEADBEEF; mscratch ends at 0xDEADBEEF.
REQ-035 RW mhartid (0xF14) -> rsp_fault=1, rsp_data=0; RS 0xF14 with rs1=0 -> rsp_fault=0, rsp_data=HARTID.
REQ-036 RW mcycle 0xFFFFFFFF with mcycleh 0 -> two cycles later mcycleh reads 1.
- Writing mcountinhibit=1 freezes mcycle.
REQ-037 mstatus MIE=1, trap_v with pc=0x1002, cause=2 -> mepc 0x1000, mcause 2, MIE 0, MPIE 1.
- A following mret restores MIE=1.
REQ-038 Hold rsp_rdy=0 for 3 cycles with req_v=1 -> req_rdy=0 and the response is stable.
- After release, the next request responds one cycle later with no loss.
REQ-039 Assert rst_n=0 while rsp_v=1 -> the next cycle rsp_v=0 and mstatus=0x1800.
